// File: rtl/intr_ctrl.sv
// Interrupt controller: system registers plus the IDLE/PEND/FIRE/DRAIN sequencer that
// raises a one-cycle TAKE redirect and saves the context needed by RETI.
module intr_ctrl #(
  parameter int DBITS = 16,
  parameter int DRAIN = 3
) (
  input  logic             CLK,
  input  logic             INIT,
  input  logic [2:0]       IRQ,
  input  logic [DBITS-1:0] MPC,
  input  logic             SAFE,
  input  logic             RETI,
  input  logic             WSR,
  input  logic [2:0]       SREGNO,
  input  logic [DBITS-1:0] WDATA,
  output logic [DBITS-1:0] SREG_OUT,
  output logic             TAKE,
  output logic [DBITS-1:0] TARGET,
  output logic [DBITS-1:0] RETPC,
  output logic             IE,
  output logic             CM
);

  localparam int CW = (DRAIN > 1) ? $clog2(DRAIN) : 1;
  localparam logic [DBITS-1:0] RSVD_VAL = DBITS'(16'hFAFA);

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_FIRE, S_DRAIN} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            capture;
  logic [1:0]      src_idx;
  logic            oie, om;
  logic [DBITS-1:0] sih, sra, sii, sr0, sr1;

  // Sequencer: detection, SAFE-gated firing, then a fixed quiet window.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    case (state)
      S_IDLE:  if (IE && (IRQ != 3'b000) && !RETI) state_nxt = S_PEND;
      S_PEND: begin
        if (!IE || (IRQ == 3'b000)) begin
          state_nxt = S_IDLE;
        end else if (SAFE) begin
          state_nxt = S_FIRE;
          capture   = 1'b1;
        end
      end
      S_FIRE: begin
        state_nxt = S_DRAIN;
        cnt_nxt   = CW'(DRAIN - 1);
      end
      S_DRAIN: begin
        if (cnt == '0) state_nxt = S_IDLE;
        else           cnt_nxt   = cnt - CW'(1);
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge INIT) begin
    if (INIT) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign TAKE = (state == S_FIRE);

  // Timer has highest priority, switches lowest.
  always_comb begin
    if (IRQ[0])      src_idx = 2'd0;
    else if (IRQ[1]) src_idx = 2'd1;
    else             src_idx = 2'd2;
  end

  // Later assignments win: RETI restore, then WSR, then the interrupt capture.
  always_ff @(posedge CLK or posedge INIT) begin
    if (INIT) begin
      IE  <= 1'b0;
      oie <= 1'b0;
      CM  <= 1'b1;
      om  <= 1'b0;
      sih <= '0;
      sra <= '0;
      sii <= '0;
      sr0 <= '0;
      sr1 <= '0;
    end else begin
      if (RETI) begin
        IE <= oie;
        CM <= om;
      end
      if (WSR) begin
        case (SREGNO)
          3'd0: {om, CM, oie, IE} <= WDATA[3:0];
          3'd1: sih <= WDATA;
          3'd2: sra <= WDATA;
          3'd3: sii <= WDATA;
          3'd6: sr0 <= WDATA;
          3'd7: sr1 <= WDATA;
          default: ;
        endcase
      end
      if (capture) begin
        sra <= MPC;
        sii <= DBITS'(src_idx);
        oie <= IE;
        IE  <= 1'b0;
        om  <= CM;
        CM  <= 1'b1;
      end
    end
  end

  always_comb begin
    SREG_OUT = RSVD_VAL;
    case (SREGNO)
      3'd0: SREG_OUT = {{(DBITS-4){1'b0}}, om, CM, oie, IE};
      3'd1: SREG_OUT = sih;
      3'd2: SREG_OUT = sra;
      3'd3: SREG_OUT = sii;
      3'd6: SREG_OUT = sr0;
      3'd7: SREG_OUT = sr1;
      default: SREG_OUT = RSVD_VAL;
    endcase
  end

  assign TARGET = sih;
  assign RETPC  = sra;

endmodule

// File: tb/tb_intr_ctrl.sv
// Bench for intr_ctrl: directed scenarios with literal expectations, plus a
// timeline-style reference model compared against every output on each falling edge.
module tb_intr_ctrl;

  localparam int TD = 3;

  logic        CLK, INIT, SAFE, RETI, WSR, TAKE, IE, CM;
  logic [2:0]  IRQ, SREGNO;
  logic [15:0] MPC, WDATA, SREG_OUT, TARGET, RETPC;

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;

  intr_ctrl #(.DBITS(16), .DRAIN(TD)) dut (
    .CLK(CLK), .INIT(INIT), .IRQ(IRQ), .MPC(MPC), .SAFE(SAFE), .RETI(RETI),
    .WSR(WSR), .SREGNO(SREGNO), .WDATA(WDATA), .SREG_OUT(SREG_OUT),
    .TAKE(TAKE), .TARGET(TARGET), .RETPC(RETPC), .IE(IE), .CM(CM)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: pending flag, redirect flag and a quiet-time countdown.
  bit          m_pend = 0, m_take = 0;
  int          m_cool = 0;
  bit          m_ie = 0, m_oie = 0, m_cm = 1, m_om = 0;
  logic [15:0] m_sr [0:7];

  function automatic logic [15:0] mread(input logic [2:0] n);
    if (n == 3'd0) return {12'h000, m_om, m_cm, m_oie, m_ie};
    if (n == 3'd4 || n == 3'd5) return 16'hFAFA;
    return m_sr[n];
  endfunction

  task automatic mreset();
    m_pend = 0; m_take = 0; m_cool = 0;
    m_ie = 0; m_oie = 0; m_cm = 1; m_om = 0;
    for (int i = 0; i < 8; i++) m_sr[i] = 16'h0000;
  endtask

  task automatic mstep();
    bit cap, ie0, cm0;
    int first;
    cap = 0; ie0 = m_ie; cm0 = m_cm;
    if (m_take) begin
      m_take = 0;
      m_cool = TD;
    end else if (m_cool > 0) begin
      m_cool = m_cool - 1;
    end else if (m_pend) begin
      if (!ie0 || IRQ == 3'b000) m_pend = 0;
      else if (SAFE) begin m_pend = 0; m_take = 1; cap = 1; end
    end else if (ie0 && IRQ != 3'b000 && !RETI) begin
      m_pend = 1;
    end
    if (RETI) begin m_ie = m_oie; m_cm = m_om; end
    if (WSR) begin
      if (SREGNO == 3'd0) {m_om, m_cm, m_oie, m_ie} = WDATA[3:0];
      else if (SREGNO != 3'd4 && SREGNO != 3'd5) m_sr[SREGNO] = WDATA;
    end
    if (cap) begin
      first = 2;
      for (int i = 2; i >= 0; i--) if (IRQ[i]) first = i;
      m_sr[2] = MPC;
      m_sr[3] = 16'(first);
      m_oie = ie0; m_ie = 0;
      m_om = cm0;  m_cm = 1;
    end
  endtask

  initial mreset();

  always @(posedge CLK or posedge INIT) begin
    if (INIT) mreset();
    else      mstep();
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("cmp_take",   {31'b0, TAKE}, {31'b0, m_take});
      chk("cmp_target", {16'b0, TARGET}, {16'b0, m_sr[1]});
      chk("cmp_retpc",  {16'b0, RETPC}, {16'b0, m_sr[2]});
      chk("cmp_ie",     {31'b0, IE}, {31'b0, m_ie});
      chk("cmp_cm",     {31'b0, CM}, {31'b0, m_cm});
      chk("cmp_sreg",   {16'b0, SREG_OUT}, {16'b0, mread(SREGNO)});
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic wsr(input logic [2:0] n, input logic [15:0] d);
    SREGNO = n; WDATA = d; WSR = 1'b1;
    cyc();
    WSR = 1'b0; SREGNO = 3'd0;
  endtask

  task automatic rd(input string name, input logic [2:0] n, input logic [15:0] exp);
    SREGNO = n;
    #1;
    chk(name, {16'b0, SREG_OUT}, {16'b0, exp});
    SREGNO = 3'd0;
  endtask

  initial begin
    INIT = 1'b1; IRQ = 3'b000; MPC = 16'h0000; SAFE = 1'b0; RETI = 1'b0;
    WSR = 1'b0; SREGNO = 3'd0; WDATA = 16'h0000;
    cyc(); cyc();
    chk("rst_take", {31'b0, TAKE}, 32'd0);
    chk("rst_ie",   {31'b0, IE}, 32'd0);
    chk("rst_cm",   {31'b0, CM}, 32'd1);
    chk("rst_target", {16'b0, TARGET}, 32'h0);
    chk("rst_retpc",  {16'b0, RETPC}, 32'h0);
    rd("rst_scs", 3'd0, 16'h0004);
    chk_en = 1'b1;
    INIT = 1'b0;
    cyc();

    // Scratch registers and reserved numbers
    wsr(3'd6, 16'hA5A5);
    wsr(3'd7, 16'h5A5A);
    wsr(3'd5, 16'hFFFF);
    wsr(3'd4, 16'h1234);
    rd("sr0_rd", 3'd6, 16'hA5A5);
    rd("sr1_rd", 3'd7, 16'h5A5A);
    rd("rsvd5_rd", 3'd5, 16'hFAFA);
    rd("scs_after_rsvd", 3'd0, 16'h0004);

    // Basic take
    wsr(3'd1, 16'h0400);
    wsr(3'd0, 16'h0001);
    chk("basic_ie_on", {31'b0, IE}, 32'd1);
    SAFE = 1'b1; MPC = 16'h0212; IRQ = 3'b010;
    cyc();
    chk("basic_take_pend", {31'b0, TAKE}, 32'd0);
    cyc();
    chk("basic_take_fire", {31'b0, TAKE}, 32'd1);
    chk("basic_target", {16'b0, TARGET}, 32'h0400);
    chk("basic_sra", {16'b0, RETPC}, 32'h0212);
    rd("basic_scs", 3'd0, 16'h0006);
    rd("basic_sii", 3'd3, 16'h0001);
    cyc();
    chk("basic_take_drop", {31'b0, TAKE}, 32'd0);

    // RETI during the quiet window
    IRQ = 3'b000; RETI = 1'b1;
    cyc();
    RETI = 1'b0;
    chk("reti_ie", {31'b0, IE}, 32'd1);
    chk("reti_cm", {31'b0, CM}, 32'd0);
    chk("reti_retpc", {16'b0, RETPC}, 32'h0212);
    chk("reti_take", {31'b0, TAKE}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("reti_drain_take", {31'b0, TAKE}, 32'd0);
    end

    // Priority with SAFE stall
    SAFE = 1'b0; IRQ = 3'b110;
    cyc();
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_take", {31'b0, TAKE}, 32'd0);
    end
    SAFE = 1'b1;
    cyc();
    chk("stall_fire", {31'b0, TAKE}, 32'd1);
    rd("stall_sii", 3'd3, 16'h0001);
    IRQ = 3'b000;
    cyc();
    chk("stall_once", {31'b0, TAKE}, 32'd0);
    RETI = 1'b1;
    cyc();
    RETI = 1'b0;
    chk("stall_reti_ie", {31'b0, IE}, 32'd1);
    repeat (3) cyc();

    // Cancel from PEND by clearing IE
    SAFE = 1'b0; IRQ = 3'b001;
    cyc();
    wsr(3'd0, 16'h0000);
    SAFE = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("cancel_take", {31'b0, TAKE}, 32'd0);
    end
    rd("cancel_scs", 3'd0, 16'h0000);
    IRQ = 3'b000;

    // WSR to SRA colliding with capture, then reset during DRAIN
    wsr(3'd0, 16'h0001);
    SAFE = 1'b0; MPC = 16'h0300; IRQ = 3'b100;
    cyc();
    SAFE = 1'b1; SREGNO = 3'd2; WDATA = 16'h1234; WSR = 1'b1;
    cyc();
    WSR = 1'b0; SREGNO = 3'd0;
    chk("coll_take", {31'b0, TAKE}, 32'd1);
    chk("coll_sra", {16'b0, RETPC}, 32'h0300);
    rd("coll_sii", 3'd3, 16'h0002);
    IRQ = 3'b000;
    cyc();
    chk("coll_drain_take", {31'b0, TAKE}, 32'd0);
    #2;
    INIT = 1'b1;
    #1;
    chk("init_take", {31'b0, TAKE}, 32'd0);
    chk("init_ie", {31'b0, IE}, 32'd0);
    chk("init_cm", {31'b0, CM}, 32'd1);
    chk("init_target", {16'b0, TARGET}, 32'h0);
    chk("init_retpc", {16'b0, RETPC}, 32'h0);
    rd("init_rsvd4", 3'd4, 16'hFAFA);
    rd("init_scs", 3'd0, 16'h0004);
    rd("init_sr0", 3'd6, 16'h0000);
    cyc(); cyc();
    INIT = 1'b0;
    cyc();
    chk("post_init_take", {31'b0, TAKE}, 32'd0);

    // RETI blocks detection; RETI and WSR-to-SCS on one edge
    wsr(3'd0, 16'h0003);
    IRQ = 3'b001; SAFE = 1'b1; RETI = 1'b1;
    cyc();
    RETI = 1'b0;
    chk("reti_block_0", {31'b0, TAKE}, 32'd0);
    cyc();
    chk("reti_block_1", {31'b0, TAKE}, 32'd0);
    cyc();
    chk("reti_block_fire", {31'b0, TAKE}, 32'd1);
    rd("reti_block_sii", 3'd3, 16'h0000);
    IRQ = 3'b000;
    cyc();
    SREGNO = 3'd0; WDATA = 16'hFFF8; WSR = 1'b1; RETI = 1'b1;
    cyc();
    WSR = 1'b0; RETI = 1'b0;
    rd("wsr_over_reti", 3'd0, 16'h0008);
    chk("wsr_over_reti_ie", {31'b0, IE}, 32'd0);
    repeat (4) cyc();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/intr_ctrl.md
INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 Parameter DBITS, default 16: data width of system registers and PC values.
REQ-002 Parameter DRAIN, default 3: cycles the block waits after an interrupt redirect before it can detect another interrupt.
REQ-003 CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 INIT  input  1  reset, asynchronous, active-high.
REQ-005 IRQ  input  3  level interrupt requests: bit0 timer, bit1 keys, bit2 switches.
REQ-006 MPC  input  DBITS  restart PC of the oldest uncommitted instruction.
REQ-007 SAFE  input  1  pipeline can accept a redirect this cycle (no branch/JMP flush in flight).
REQ-008 RETI  input  1  RETI commits this cycle.
REQ-009 WSR  input  1  WSR commits this cycle.
REQ-010 SREGNO  input  3  system register number for RSR/WSR: 0 SCS, 1 SIH, 2 SRA, 3 SII, 4-5 reserved, 6 SR0, 7 SR1.
REQ-011 WDATA  input  DBITS  WSR write data.
REQ-012 SREG_OUT  output  DBITS  combinational read of the register selected by SREGNO.
REQ-013 TAKE  output  1  registered one-cycle redirect-and-flush pulse.
REQ-014 TARGET  output  DBITS  handler address; always equals SIH.
REQ-015 RETPC  output  DBITS  RETI return address; always equals SRA.
REQ-016 IE, CM  output  1 each  current interrupt-enable and system-mode bits.

Function
REQ-017 SCS SHALL read as {zeros, OM, CM, OIE, IE}; reserved numbers SHALL read 16'hFAFA.
REQ-018 FSM states SHALL be IDLE, PEND, FIRE and DRAIN.
REQ-019 IDLE->PEND SHALL occur on an edge where IE=1, IRQ!=0 and RETI=0.
REQ-020 PEND->IDLE SHALL occur when IE=0 or IRQ=0; otherwise PEND->FIRE SHALL occur on the first edge with SAFE=1.
REQ-021 TAKE SHALL be 1 exactly while the state is FIRE; FIRE->DRAIN SHALL occur unconditionally.
REQ-022 DRAIN SHALL last exactly DRAIN cycles via a down-counter, then go to IDLE.
REQ-023 On the PEND->FIRE edge: SRA<=MPC, OIE<=IE, IE<=0, OM<=CM, CM<=1, and SII<=lowest set IRQ index (timer > keys > switches), zero-extended.
REQ-024 Source selection SHALL use the IRQ value sampled on the PEND->FIRE edge.
REQ-025 RETI SHALL apply IE<=OIE and CM<=OM on its edge; RETI SHALL NOT itself change the FSM state.
REQ-026 WSR to SCS SHALL write WDATA[3:0] into {OM,CM,OIE,IE}.
REQ-027 WSR to SIH, SRA, SII, SR0 or SR1 SHALL write the full WDATA.
REQ-028 WSR to a reserved number SHALL have no effect.
REQ-029 When WSR and the PEND->FIRE capture hit the same edge, the capture values SHALL win for SRA, SII, IE, OIE, CM and OM; non-overlapping WSR fields SHALL still be written.
REQ-030 When RETI and WSR-to-SCS hit the same edge, the WSR values SHALL win.
REQ-031 While IE=0, IRQ SHALL be ignored with no latching; requests are level-sensitive and MUST remain asserted until serviced.
REQ-032 Each IRQ bit SHALL be sampled only as a level; no edge detection.

Reset
REQ-033 INIT=1 SHALL asynchronously force: state IDLE, TAKE=0, drain counter 0, IE=0, OIE=0, CM=1, OM=0, SIH=SRA=SII=SR0=SR1=0.
REQ-034 Assertion of INIT mid-PEND, mid-FIRE or mid-DRAIN SHALL abort the sequence with no further TAKE pulse.
REQ-035 The first state change after INIT deasserts SHALL occur on the next CLK edge.

Verification
REQ-036 Basic take: WSR SIH=0x0400; WSR SCS=0x1; IRQ=3'b010, SAFE=1, MPC=0x0212 -> TAKE pulses one cycle, 2 cycles after the IRQ edge; TARGET=0x0400, SRA=0x0212, SII=1, SCS reads 0x6.
REQ-037 Priority and SAFE stall: IRQ=3'b110, SAFE=0 for 4 cycles then 1 -> TAKE fires once, in the cycle after SAFE rises; SII=1.
REQ-038 RETI: after REQ-036, drop IRQ and pulse RETI -> IE=1, CM=0, RETPC=0x0212; no TAKE during the DRAIN window or on the RETI edge.
REQ-039 Cancel: enter PEND with SAFE=0, then WSR SCS=0x0 -> FSM returns to IDLE and TAKE never asserts.
REQ-040 Collision and reset: WSR SRA=0x1234 on the PEND->FIRE edge with MPC=0x0300 -> SRA=0x0300; later assert INIT during DRAIN -> all outputs return to reset values immediately, and SREGNO=4 reads 0xFAFA.
